// File: rtl/alu_div_pkg.sv
// alu_div_pkg: shared state type and constants for the sequential ALU divider
package alu_div_pkg;
  typedef enum logic [1:0] {IDLE, CALC, DONE} div_state_t;
  localparam int DIV_WIDTH_DEF = 16;
  localparam logic [DIV_WIDTH_DEF-1:0] DIV0_QUOTIENT = '1;
endpackage

// File: rtl/alu_sub16.sv
// alu_sub16: WIDTH-bit subtractor a + ~b + 1 with borrow out
module alu_sub16 #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);
  logic carry;
  assign {carry, diff} = {1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(1);
  assign borrow_out = ~carry;
endmodule

// File: rtl/alu_div16_seq.sv
// alu_div16_seq: iterative restoring divider, one shift-subtract per clock
// Optional two's-complement support is built when ALU_SIGNED_DIV_EN is defined.
module alu_div16_seq
  import alu_div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             op_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);
  localparam int CW = $clog2(WIDTH) + 1;
  div_state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
  logic [WIDTH-1:0] q_out_q, q_out_d, r_out_q, r_out_d;
  logic dbz_q, dbz_d;
  logic [WIDTH-1:0] rem_sh, diff, rem_n, quo_n, a_mag, b_mag, q_fix, r_fix;
  logic borrow, ok, accept;
  assign rem_sh = {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};
  alu_sub16 #(.WIDTH(WIDTH)) u_sub (
    .a         (rem_sh),
    .b         (dvs_q),
    .diff      (diff),
    .borrow_out(borrow)
  );
  // a set MSB before the shift means the shifted remainder exceeds any divisor
  assign ok     = rem_q[WIDTH-1] | ~borrow;
  assign rem_n  = ok ? diff : rem_sh;
  assign quo_n  = {quo_q[WIDTH-2:0], ok};
  assign accept = start & (state_q != CALC);
`ifdef ALU_SIGNED_DIV_EN
  logic neg_q_q, neg_q_d, neg_r_q, neg_r_d, sa, sb;
  assign sa      = op_signed & dividend[WIDTH-1];
  assign sb      = op_signed & divisor[WIDTH-1];
  assign a_mag   = sa ? -dividend : dividend;
  assign b_mag   = sb ? -divisor : divisor;
  assign neg_q_d = accept ? sa ^ sb : neg_q_q;
  assign neg_r_d = accept ? sa : neg_r_q;
  assign q_fix   = neg_q_q ? -quo_n : quo_n;
  assign r_fix   = neg_r_q ? -rem_n : rem_n;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      neg_q_q <= 1'b0;
      neg_r_q <= 1'b0;
    end else begin
      neg_q_q <= neg_q_d;
      neg_r_q <= neg_r_d;
    end
  end
`else
  logic unused_sign;
  assign unused_sign = op_signed;
  assign a_mag = dividend;
  assign b_mag = divisor;
  assign q_fix = quo_n;
  assign r_fix = rem_n;
`endif
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    q_out_d = q_out_q;
    r_out_d = r_out_q;
    dbz_d   = dbz_q;
    if (accept) begin
      dbz_d   = divisor == '0;
      state_d = dbz_d ? DONE : CALC;
      cnt_d   = CW'(WIDTH);
      rem_d   = '0;
      quo_d   = a_mag;
      dvs_d   = b_mag;
      q_out_d = dbz_d ? '1 : q_out_q;
      r_out_d = dbz_d ? dividend : r_out_q;
    end else if (state_q == CALC) begin
      rem_d = rem_n;
      quo_d = quo_n;
      cnt_d = cnt_q - 1'b1;
      if (cnt_q == CW'(1)) begin
        state_d = DONE;
        q_out_d = q_fix;
        r_out_d = r_fix;
      end
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      q_out_q <= '0;
      r_out_q <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      q_out_q <= q_out_d;
      r_out_q <= r_out_d;
      dbz_q   <= dbz_d;
    end
  end
  assign busy        = state_q == CALC;
  assign done        = state_q == DONE;
  assign quotient    = q_out_q;
  assign remainder   = r_out_q;
  assign div_by_zero = dbz_q;
endmodule

// File: tb/tb_alu_div16_seq.sv
// tb_alu_div16_seq: table-driven and scoreboard checks of the sequential divider
module tb_alu_div16_seq;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, op_signed = 1'b0;
  logic [15:0] dividend = '0, divisor = '0;
  logic busy, done, div_by_zero;
  logic [15:0] quotient, remainder;
  alu_div16_seq #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op_signed(op_signed),
    .dividend(dividend), .divisor(divisor), .busy(busy), .done(done),
    .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero)
  );
  always #5 clk = ~clk;
  typedef struct {logic [15:0] q; logic [15:0] r; logic dbz;} exp_t;
  typedef struct {logic [15:0] a; logic [15:0] b; logic s; logic [15:0] q; logic [15:0] r; logic dbz; int lat;} vec_t;
  exp_t sb_q[$];
  vec_t tbl[12];
  int n_vec = 0, n_err = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b, input logic s);
    exp_t e;
    e.dbz = 1'b0;
    if (b == 16'd0) begin
      e.q = 16'hFFFF; e.r = a; e.dbz = 1'b1;
      return e;
    end
`ifdef ALU_SIGNED_DIV_EN
    if (s) begin
      int sa, sd;
      sa = int'($signed(a));
      sd = int'($signed(b));
      e.q = 16'(sa / sd);
      e.r = 16'(sa % sd);
      return e;
    end
`endif
    e.q = a / b; e.r = a % b;
    return e;
  endfunction
  task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic s, input exp_t e);
    dividend = a; divisor = b; op_signed = s; start = 1'b1;
    sb_q.push_back(e);
  endtask
  task automatic wait_done(input string name, input int lat, input bit glitch);
    int k = 0, nb = 0;
    exp_t e;
    @(posedge clk);
    forever begin
      @(negedge clk);
      k++;
      if (k == 1) start = 1'b0;
      if (glitch && k == 5) begin start = 1'b1; dividend = 16'h0F0F; divisor = 16'h0003; end
      if (glitch && k == 6) start = 1'b0;
      if (busy) nb++;
      if (done || k > 40) break;
    end
    chk({name, " latency"}, k, lat);
    chk({name, " busy cycles"}, nb, lat - 1);
    e = sb_q.pop_front();
    chk({name, " quotient"}, quotient, e.q);
    chk({name, " remainder"}, remainder, e.r);
    chk({name, " div_by_zero"}, div_by_zero, e.dbz);
  endtask
  initial begin
    exp_t e;
    tbl[0] = '{16'd100, 16'd7, 1'b0, 16'd14, 16'd2, 1'b0, 17};
    tbl[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'hFFFF, 16'h0000, 1'b0, 17};
    tbl[2] = '{16'h1234, 16'h0000, 1'b0, 16'hFFFF, 16'h1234, 1'b1, 1};
    tbl[3] = '{16'h0000, 16'h0005, 1'b0, 16'h0000, 16'h0000, 1'b0, 17};
    tbl[4] = '{16'h0005, 16'hFFFF, 1'b0, 16'h0000, 16'h0005, 1'b0, 17};
    tbl[5] = '{16'hFFFF, 16'hFFFF, 1'b0, 16'h0001, 16'h0000, 1'b0, 17};
    tbl[6] = '{16'hFFFE, 16'h8001, 1'b0, 16'h0001, 16'h7FFD, 1'b0, 17};
    tbl[7] = '{16'h8000, 16'hFFFF, 1'b0, 16'h0000, 16'h8000, 1'b0, 17};
    tbl[8] = '{16'hFFF9, 16'h0000, 1'b1, 16'hFFFF, 16'hFFF9, 1'b1, 1};
`ifdef ALU_SIGNED_DIV_EN
    tbl[9]  = '{16'hFFF9, 16'h0002, 1'b1, 16'hFFFD, 16'hFFFF, 1'b0, 17};
    tbl[10] = '{16'h8000, 16'hFFFF, 1'b1, 16'h8000, 16'h0000, 1'b0, 17};
    tbl[11] = '{16'h0007, 16'hFFFE, 1'b1, 16'hFFFD, 16'h0001, 1'b0, 17};
`else
    tbl[9]  = '{16'hFFF9, 16'h0002, 1'b1, 16'h7FFC, 16'h0001, 1'b0, 17};
    tbl[10] = '{16'h8000, 16'hFFFF, 1'b1, 16'h0000, 16'h8000, 1'b0, 17};
    tbl[11] = '{16'h0007, 16'hFFFE, 1'b1, 16'h0000, 16'h0007, 1'b0, 17};
`endif
    #12;
    chk("reset busy/done/dbz", {busy, done, div_by_zero}, 3'b000);
    chk("reset quotient", quotient, 16'h0000);
    chk("reset remainder", remainder, 16'h0000);
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    foreach (tbl[i]) begin
      issue(tbl[i].a, tbl[i].b, tbl[i].s, '{tbl[i].q, tbl[i].r, tbl[i].dbz});
      wait_done($sformatf("vec%0d", i), tbl[i].lat, 1'b0);
      @(negedge clk);
      chk($sformatf("vec%0d done pulse", i), done, 1'b0);
      chk($sformatf("vec%0d held quotient", i), quotient, tbl[i].q);
    end
    issue(16'd100, 16'd7, 1'b0, '{16'd14, 16'd2, 1'b0});
    wait_done("mid-calc start ignored", 17, 1'b1);
    issue(16'h1234, 16'h0000, 1'b0, '{16'hFFFF, 16'h1234, 1'b1});
    wait_done("b2b div0", 1, 1'b0);
    issue(16'hFFFF, 16'h0001, 1'b0, '{16'hFFFF, 16'h0000, 1'b0});
    wait_done("b2b after div0", 17, 1'b0);
    @(negedge clk);
    issue(16'd1000, 16'd3, 1'b0, '{16'd333, 16'd1, 1'b0});
    @(posedge clk);
    repeat (8) begin @(negedge clk); start = 1'b0; end
    #2 rst_n = 1'b0;
    #1;
    chk("abort busy/done/dbz", {busy, done, div_by_zero}, 3'b000);
    chk("abort quotient", quotient, 16'h0000);
    chk("abort remainder", remainder, 16'h0000);
    sb_q.delete();
    repeat (3) begin
      @(negedge clk);
      chk("abort no done", {busy, done}, 2'b00);
    end
    rst_n = 1'b1;
    @(negedge clk);
    issue(16'd50000, 16'd123, 1'b0, '{16'd406, 16'd62, 1'b0});
    wait_done("after abort", 17, 1'b0);
    for (int i = 0; i < 24; i++) begin
      logic [15:0] a, b;
      logic s;
      a = 16'($urandom);
      b = (i % 4 == 0) ? 16'($urandom_range(16'h8000, 16'hFFFF)) : 16'($urandom_range(0, 16'hFFFF) >> (i % 12));
      s = 1'($urandom);
      e = model(a, b, s);
      @(negedge clk);
      issue(a, b, s, e);
      wait_done($sformatf("rnd%0d %h/%h s%0d", i, a, b, s), (b == 16'd0) ? 1 : 17, 1'b0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
